inputc_nvc: RTL and testbench

Parametrised router input channel: one physical input link demultiplexed into `NVC` virtual-channel FIFOs. Each VC runs its own packet state machine covering route latch, output-VC allocation and active forwarding. A round-robin selector picks one eligible VC per cycle to request the crossbar. It is the next generation of the single-VC input channel and sits between the upstream link and the switch allocator/crossbar of each router port.

---
 rtl/noc_pkg.sv | 23 ++
 rtl/vc_fifo.sv | 57 +++++
 rtl/inputc_nvc.sv | 161 ++++++++++++++++
 tb/tb_inputc_nvc.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit type codes, type-field geometry, VC state enum and
// index-width helpers.
package noc_pkg;

    localparam int unsigned TYPE_W = 2;

    localparam logic [TYPE_W-1:0] FLIT_BODY     = 2'b00;
    localparam logic [TYPE_W-1:0] FLIT_HEAD     = 2'b01;
    localparam logic [TYPE_W-1:0] FLIT_TAIL     = 2'b10;
    localparam logic [TYPE_W-1:0] FLIT_HEADTAIL = 2'b11;

    typedef enum logic [1:0] {
        VcIdle,
        VcAlloc,
        VcActive
    } vc_state_e;

    // Index width that stays legal (>=1) even for a single-entry range.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vc_fifo.sv
// Per-VC circular flit buffer with occupancy count and a registered not-full flag.
module vc_fifo #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 35,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic              ordy
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [AW:0]       count_q, count_d;
    logic              do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem_q[rptr_q];

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_rd && !do_wr) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ordy    <= 1'b1;
        end else begin
            if (do_wr) begin
                mem_q[wptr_q] <= wr_data;
                wptr_q        <= wptr_q + AW'(1);
            end
            if (do_rd) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            ordy    <= (count_d != (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/inputc_nvc.sv
// Router input channel: one link demuxed into NVC VC FIFOs, per-VC packet FSMs,
// round-robin crossbar request and a registered output flit stage.
module inputc_nvc
    import noc_pkg::*;
#(
    parameter int unsigned NVC       = 4,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned NPORT     = 5,
    parameter int unsigned DATA_W    = 35,
    parameter int unsigned ROUTE_LSB = 0,
    localparam int unsigned VCW      = idx_w(NVC),
    localparam int unsigned PORTW    = idx_w(NPORT)
) (
    input  logic                 clk,
    input  logic                 rst_,
    input  logic [DATA_W-1:0]    idata,
    input  logic                 ivalid,
    input  logic [VCW-1:0]       ivch,
    output logic [NVC-1:0]       ordy,
    output logic [NVC-1:0]       oack,
    output logic [NVC-1:0]       olck,
    input  logic [NPORT*NVC-1:0] irdy,
    input  logic [NPORT*NVC-1:0] ilck,
    input  logic [NPORT-1:0]     grt,
    output logic                 req,
    output logic [PORTW-1:0]     port,
    output logic [DATA_W-1:0]    odata,
    output logic                 ovalid,
    output logic [VCW-1:0]       ovch,
    output logic                 err
);

    logic [NVC-1:0]    wr_en, pop, full, empty, elig, discard, free_ok;
    logic [DATA_W-1:0] head [NVC];
    vc_state_e         state_q [NVC];
    logic [PORTW-1:0]  vport_q [NVC];
    logic [VCW-1:0]    vovc_q [NVC];
    logic [VCW-1:0]    free_vc [NVC];
    logic [VCW-1:0]    rr_q, winner;
    logic [NVC-1:0]    rot;
    logic [NPORT-1:0]  gsh;
    logic              send, err_q;

    // Out-of-range (port, vc) pairs shift to zero, so they read as not ready / not free.
    function automatic logic bit_at(input logic [NPORT*NVC-1:0] vec, input logic [PORTW-1:0] p,
                                    input logic [VCW-1:0] c);
        logic [NPORT*NVC-1:0] sh;
        sh = vec >> (int'(p) * NVC + int'(c));
        return sh[0];
    endfunction

    for (genvar g = 0; g < NVC; g++) begin : g_vc
        assign wr_en[g] = ivalid && (ivch == VCW'(g));
        assign olck[g]  = (state_q[g] != VcIdle);

        vc_fifo #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .rst_    (rst_),
            .wr_en   (wr_en[g]),
            .wr_data (idata),
            .rd_en   (pop[g]),
            .rd_data (head[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .ordy    (ordy[g])
        );
    end

    // Type bit DATA_W-2 marks a head, bit DATA_W-1 marks a tail.
    always_comb begin
        elig    = '0;
        discard = '0;
        free_ok = '0;
        for (int v = 0; v < NVC; v++) begin
            free_vc[v] = '0;
            elig[v]    = (state_q[v] == VcActive) && !empty[v] &&
                         bit_at(irdy, vport_q[v], vovc_q[v]);
            discard[v] = (state_q[v] == VcIdle) && !empty[v] && !head[v][DATA_W-2];
            for (int c = NVC - 1; c >= 0; c--) begin
                if (bit_at(~ilck, vport_q[v], VCW'(c))) begin
                    free_ok[v] = 1'b1;
                    free_vc[v] = VCW'(c);
                end
            end
        end
    end

    always_comb begin
        req    = 1'b0;
        winner = '0;
        rot    = '0;
        for (int i = 0; i < NVC; i++) begin
            rot = elig >> ((int'(rr_q) + i) % NVC);
            if (!req && rot[0]) begin
                req    = 1'b1;
                winner = VCW'((int'(rr_q) + i) % NVC);
            end
        end
        port = req ? vport_q[winner] : '0;
        gsh  = grt >> port;
        send = req && gsh[0];
        pop  = discard;
        if (send) begin
            pop[winner] = 1'b1;
        end
    end

    assign oack = pop;
    assign err  = err_q;

    always_ff @(posedge clk) begin
        if (rst_) begin
            for (int v = 0; v < NVC; v++) begin
                state_q[v] <= VcIdle;
                vport_q[v] <= '0;
                vovc_q[v]  <= '0;
            end
            rr_q   <= '0;
            err_q  <= 1'b0;
            odata  <= '0;
            ovalid <= 1'b0;
            ovch   <= '0;
        end else begin
            for (int v = 0; v < NVC; v++) begin
                unique case (state_q[v])
                    VcIdle: begin
                        if (!empty[v] && head[v][DATA_W-2]) begin
                            vport_q[v] <= head[v][ROUTE_LSB +: PORTW];
                            state_q[v] <= VcAlloc;
                        end
                    end
                    VcAlloc: begin
                        if (free_ok[v]) begin
                            vovc_q[v]  <= free_vc[v];
                            state_q[v] <= VcActive;
                        end
                    end
                    VcActive: begin
                        if (send && winner == VCW'(v) && head[v][DATA_W-1]) begin
                            state_q[v] <= VcIdle;
                        end
                    end
                    default: state_q[v] <= VcIdle;
                endcase
            end
            if ((wr_en & full) != '0 || discard != '0) begin
                err_q <= 1'b1;
            end
            ovalid <= send;
            odata  <= send ? head[winner] : '0;
            ovch   <= send ? vovc_q[winner] : '0;
            if (send) begin
                rr_q <= (winner == VCW'(NVC - 1)) ? '0 : winner + VCW'(1);
            end
        end
    end

endmodule

// File: tb/tb_inputc_nvc.sv
// Randomized bench for inputc_nvc against a queue-based packet model, plus directed scenarios.
module tb_inputc_nvc;
    import noc_pkg::*;

    localparam int unsigned NVC       = 4;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned NPORT     = 5;
    localparam int unsigned DATA_W    = 35;
    localparam int unsigned ROUTE_LSB = 0;
    localparam int unsigned VCW       = 2;
    localparam int unsigned PORTW     = 3;

    logic                 clk = 1'b0;
    logic                 rst_;
    logic [DATA_W-1:0]    idata;
    logic                 ivalid;
    logic [VCW-1:0]       ivch;
    logic [NVC-1:0]       ordy, oack, olck;
    logic [NPORT*NVC-1:0] irdy, ilck;
    logic [NPORT-1:0]     grt;
    logic                 req;
    logic [PORTW-1:0]     port;
    logic [DATA_W-1:0]    odata;
    logic                 ovalid;
    logic [VCW-1:0]       ovch;
    logic                 err;

    always #5 clk = ~clk;

    inputc_nvc #(
        .NVC       (NVC),
        .DEPTH     (DEPTH),
        .NPORT     (NPORT),
        .DATA_W    (DATA_W),
        .ROUTE_LSB (ROUTE_LSB)
    ) dut (
        .clk    (clk),
        .rst_   (rst_),
        .idata  (idata),
        .ivalid (ivalid),
        .ivch   (ivch),
        .ordy   (ordy),
        .oack   (oack),
        .olck   (olck),
        .irdy   (irdy),
        .ilck   (ilck),
        .grt    (grt),
        .req    (req),
        .port   (port),
        .odata  (odata),
        .ovalid (ovalid),
        .ovch   (ovch),
        .err    (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: per-VC flit queues and packet phase (0 idle, 1 waiting VC, 2 forwarding).
    logic [DATA_W-1:0] mq [NVC][$];
    int                m_state [NVC];
    int                m_port [NVC];
    int                m_ovc [NVC];
    int                m_rr, m_ovch;
    bit                m_err, m_ovalid;
    logic [DATA_W-1:0] m_odata;
    bit                e_req, e_send;
    int                e_port, e_win;
    logic [NVC-1:0]    e_oack;
    int                gen_rem [NVC];

    function automatic logic [1:0] ftype(input logic [DATA_W-1:0] f);
        return f[DATA_W-1 -: 2];
    endfunction

    function automatic logic [DATA_W-1:0] make_flit(input logic [1:0] t, input int route);
        logic [DATA_W-1:0] f;
        f = DATA_W'({$urandom, $urandom});
        f[DATA_W-1 -: 2] = t;
        f[ROUTE_LSB +: PORTW] = PORTW'(route);
        return f;
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NVC; v++) begin
            mq[v].delete();
            m_state[v] = 0;
            m_port[v]  = 0;
            m_ovc[v]   = 0;
            gen_rem[v] = 0;
        end
        m_rr = 0; m_err = 0; m_ovalid = 0; m_odata = '0; m_ovch = 0;
    endfunction

    function automatic void model_comb();
        e_req = 0; e_win = 0; e_port = 0; e_oack = '0;
        for (int i = 0; i < NVC; i++) begin
            int v = (m_rr + i) % NVC;
            if (!e_req && m_state[v] == 2 && mq[v].size() > 0 && m_port[v] < NPORT &&
                irdy[m_port[v] * NVC + m_ovc[v]]) begin
                e_req = 1; e_win = v; e_port = m_port[v];
            end
        end
        e_send = e_req && grt[e_port];
        for (int v = 0; v < NVC; v++) begin
            if (m_state[v] == 0 && mq[v].size() > 0 &&
                (ftype(mq[v][0]) == FLIT_BODY || ftype(mq[v][0]) == FLIT_TAIL)) e_oack[v] = 1;
        end
        if (e_send) e_oack[e_win] = 1;
    endfunction

    function automatic void model_update();
        int old_size [NVC];
        if (rst_) begin
            model_reset();
            return;
        end
        for (int v = 0; v < NVC; v++) old_size[v] = mq[v].size();
        m_ovalid = e_send;
        m_odata  = e_send ? mq[e_win][0] : '0;
        m_ovch   = e_send ? m_ovc[e_win] : 0;
        if (e_send) m_rr = (e_win + 1) % NVC;
        for (int v = 0; v < NVC; v++) begin
            if (m_state[v] == 0 && mq[v].size() > 0) begin
                if (ftype(mq[v][0]) == FLIT_HEAD || ftype(mq[v][0]) == FLIT_HEADTAIL) begin
                    m_port[v]  = int'(mq[v][0][ROUTE_LSB +: PORTW]);
                    m_state[v] = 1;
                end else begin
                    m_err = 1;
                end
            end else if (m_state[v] == 1) begin
                for (int c = 0; c < NVC; c++) begin
                    if (m_port[v] < NPORT && !ilck[m_port[v] * NVC + c]) begin
                        m_ovc[v] = c;
                        m_state[v] = 2;
                        break;
                    end
                end
            end else if (m_state[v] == 2 && e_send && e_win == v &&
                         (ftype(mq[v][0]) == FLIT_TAIL || ftype(mq[v][0]) == FLIT_HEADTAIL)) begin
                m_state[v] = 0;
            end
        end
        for (int v = 0; v < NVC; v++) if (e_oack[v]) void'(mq[v].pop_front());
        if (ivalid) begin
            if (old_size[ivch] == DEPTH) m_err = 1;
            else mq[ivch].push_back(idata);
        end
    endfunction

    // One clock: compare all outputs 1 ns after the negedge, then advance the model at posedge.
    task automatic cycle();
        logic [NVC-1:0] e_ordy, e_olck;
        #1;
        model_comb();
        for (int v = 0; v < NVC; v++) begin
            e_ordy[v] = (mq[v].size() < DEPTH);
            e_olck[v] = (m_state[v] != 0);
        end
        check("ordy", 64'(ordy), 64'(e_ordy));
        check("olck", 64'(olck), 64'(e_olck));
        check("oack", 64'(oack), 64'(e_oack));
        check("req", 64'(req), 64'(e_req));
        check("port", 64'(port), 64'(e_req ? e_port : 0));
        check("ovalid", 64'(ovalid), 64'(m_ovalid));
        check("odata", 64'(odata), 64'(m_odata));
        check("ovch", 64'(ovch), 64'(m_ovch));
        check("err", 64'(err), 64'(m_err));
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_ = 1'b1; ivalid = 1'b0;
        cycle();
        rst_ = 1'b0;
    endtask

    task automatic drive_random(input int grt_pct);
        int v, len;
        ivalid = ($urandom_range(0, 9) < 7);
        ivch   = VCW'($urandom_range(0, NVC - 1));
        v      = int'(ivch);
        if (gen_rem[v] == 0) begin
            if ($urandom_range(0, 19) == 0) begin
                idata = make_flit(FLIT_BODY, 0);
            end else begin
                len   = $urandom_range(1, 4);
                idata = make_flit((len == 1) ? FLIT_HEADTAIL : FLIT_HEAD,
                                  $urandom_range(0, NPORT - 1));
                if (ivalid) gen_rem[v] = len - 1;
            end
        end else begin
            idata = make_flit((gen_rem[v] == 1) ? FLIT_TAIL : FLIT_BODY, 0);
            if (ivalid) gen_rem[v]--;
        end
        for (int b = 0; b < NPORT * NVC; b++) begin
            ilck[b] = ($urandom_range(0, 9) < 3);
            irdy[b] = ($urandom_range(0, 9) < 8);
        end
        for (int p = 0; p < NPORT; p++) grt[p] = ($urandom_range(0, 99) < grt_pct);
    endtask

    initial begin
        int first_ov, olck_cnt, oack_cnt, n_req, req_port, seen_ovch, beats;
        rst_ = 1'b1; ivalid = 1'b0; ivch = '0; idata = '0;
        irdy = '0; ilck = '0; grt = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_ordy", 64'(ordy), 64'hf);
        check("rst_olck", 64'(olck), 64'h0);
        check("rst_oack", 64'(oack), 64'h0);
        check("rst_req", 64'(req), 64'h0);
        check("rst_port", 64'(port), 64'h0);
        check("rst_ovalid", 64'(ovalid), 64'h0);
        check("rst_odata", 64'(odata), 64'h0);
        check("rst_ovch", 64'(ovch), 64'h0);
        check("rst_err", 64'(err), 64'h0);
        rst_ = 1'b0;
        @(negedge clk);

        // Single HEADTAIL on VC2 to port 3.
        ilck = '0; irdy = '1; grt = '1;
        ivalid = 1'b1; ivch = 2'd2; idata = make_flit(FLIT_HEADTAIL, 3);
        cycle();
        ivalid = 1'b0;
        first_ov = -1; olck_cnt = 0; oack_cnt = 0; n_req = 0; req_port = -1; seen_ovch = -1;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (ovalid && first_ov < 0) begin
                first_ov  = k;
                seen_ovch = int'(ovch);
            end
            olck_cnt += int'(olck[2]);
            oack_cnt += int'(oack[2]);
            if (req) begin
                n_req++;
                req_port = int'(port);
            end
            cycle();
        end
        check("ht_latency", 64'(first_ov), 64'd4);
        check("ht_ovch", 64'(seen_ovch), 64'd0);
        check("ht_oack2", 64'(oack_cnt), 64'd1);
        check("ht_olck2", 64'(olck_cnt), 64'd2);
        check("ht_nreq", 64'(n_req), 64'd1);
        check("ht_port", 64'(req_port), 64'd3);

        // Fill VC3 with no grant, overflow it, then release one flit.
        do_reset();
        ilck = '0; irdy = '1; grt = '0;
        for (int j = 0; j < 4; j++) begin
            ivalid = 1'b1; ivch = 2'd3;
            idata = (j == 0) ? make_flit(FLIT_HEAD, 1) : make_flit(FLIT_BODY, 0);
            cycle();
        end
        ivalid = 1'b0;
        repeat (3) cycle();
        #1;
        check("full_ordy3", 64'(ordy[3]), 64'd0);
        check("full_err0", 64'(err), 64'd0);
        ivalid = 1'b1; idata = make_flit(FLIT_BODY, 0);
        cycle();
        ivalid = 1'b0;
        #1;
        check("ovf_err", 64'(err), 64'd1);
        check("ovf_ordy3", 64'(ordy[3]), 64'd0);
        grt = '1;
        cycle();
        grt = '0;
        #1;
        check("pop_ordy3", 64'(ordy[3]), 64'd1);
        check("pop_ovalid", 64'(ovalid), 64'd1);

        // Randomized traffic: busy grants, then sparse grants to build backpressure.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            drive_random(70);
            cycle();
        end
        for (int n = 0; n < 1500; n++) begin
            drive_random(20);
            cycle();
        end

        // Reset in the middle of traffic, then a fresh head must flow normally.
        rst_ = 1'b1; ivalid = 1'b0;
        cycle();
        rst_ = 1'b0;
        #1;
        check("mid_ordy", 64'(ordy), 64'hf);
        check("mid_olck", 64'(olck), 64'h0);
        check("mid_ovalid", 64'(ovalid), 64'h0);
        check("mid_odata", 64'(odata), 64'h0);
        check("mid_err", 64'(err), 64'h0);
        ilck = '0; irdy = '1; grt = '1;
        ivalid = 1'b1; ivch = 2'd0; idata = make_flit(FLIT_HEADTAIL, 2);
        cycle();
        ivalid = 1'b0;
        beats = 0;
        for (int k = 1; k <= 7; k++) begin
            #1;
            beats += int'(ovalid);
            cycle();
        end
        check("mid_beats", 64'(beats), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
